// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute controller with an embedded 4-bit ALU.
// It drives a 4x4-bit register file and fetches bytes from a combinational instruction memory.
module cpu_control_unit #(
  parameter int unsigned PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic [PC_W-1:0] imem_addr,
  input  logic [7:0]      imem_data,
  output logic            rf_we,
  output logic [1:0]      rf_waddr,
  output logic [3:0]      rf_wdata,
  output logic [1:0]      rf_raddr1,
  output logic [1:0]      rf_raddr2,
  input  logic [3:0]      rf_rdata1,
  input  logic [3:0]      rf_rdata2,
  output logic            zero_flag,
  output logic            carry_flag,
  output logic            halted,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_FETCH2 = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [7:0]      opnd_q, opnd_d;
  logic            z_q, z_d;
  logic            c_q, c_d;

  logic [3:0]      op;
  logic            two_byte;
  logic [PC_W-1:0] target;

  logic [3:0]      alu_res;
  logic            alu_c;
  logic            writes_rf;
  logic            sets_flags;
  logic [4:0]      wide;

  assign op       = ir_q[7:4];
  assign two_byte = (op == OP_LDI) || (op == OP_JMP) || (op == OP_JZ);
  assign target   = PC_W'(opnd_q);

  // ALU result, carry/borrow and the write/flag-update qualifiers for the current opcode
  always_comb begin
    alu_res    = '0;
    alu_c      = 1'b0;
    writes_rf  = 1'b0;
    sets_flags = 1'b0;
    wide       = '0;
    case (op)
      OP_LDI: begin
        alu_res   = opnd_q[3:0];
        writes_rf = 1'b1;
      end
      OP_MOV: begin
        alu_res   = rf_rdata2;
        writes_rf = 1'b1;
      end
      OP_ADD: begin
        wide       = {1'b0, rf_rdata1} + {1'b0, rf_rdata2};
        alu_res    = wide[3:0];
        alu_c      = wide[4];
        writes_rf  = 1'b1;
        sets_flags = 1'b1;
      end
      OP_SUB: begin
        wide       = {1'b0, rf_rdata1} - {1'b0, rf_rdata2};
        alu_res    = wide[3:0];
        alu_c      = wide[4];
        writes_rf  = 1'b1;
        sets_flags = 1'b1;
      end
      OP_AND: begin
        alu_res    = rf_rdata1 & rf_rdata2;
        writes_rf  = 1'b1;
        sets_flags = 1'b1;
      end
      OP_OR: begin
        alu_res    = rf_rdata1 | rf_rdata2;
        writes_rf  = 1'b1;
        sets_flags = 1'b1;
      end
      OP_XOR: begin
        alu_res    = rf_rdata1 ^ rf_rdata2;
        writes_rf  = 1'b1;
        sets_flags = 1'b1;
      end
      OP_NOT: begin
        alu_res    = ~rf_rdata2;
        writes_rf  = 1'b1;
        sets_flags = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opnd_d  = opnd_q;
    z_d     = z_q;
    c_d     = c_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = imem_data;
        pc_d    = pc_q + PC_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (two_byte)            state_d = S_FETCH2;
        else if (op == OP_HALT)  state_d = S_HALT;
        else                     state_d = S_EXEC;
      end
      S_FETCH2: begin
        opnd_d  = imem_data;
        pc_d    = pc_q + PC_W'(1);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (sets_flags) begin
          z_d = (alu_res == 4'h0);
          c_d = alu_c;
        end
        if (op == OP_JMP || (op == OP_JZ && z_q)) pc_d = target;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      opnd_q  <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opnd_q  <= opnd_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  // Gating with rst drops a write that would otherwise land on the reset edge
  assign rf_we      = (state_q == S_EXEC) && writes_rf && !rst;
  assign rf_waddr   = ir_q[3:2];
  assign rf_wdata   = alu_res;
  assign rf_raddr1  = ir_q[3:2];
  assign rf_raddr2  = ir_q[1:0];
  assign imem_addr  = pc_q;
  assign zero_flag  = z_q;
  assign carry_flag = c_q;
  assign halted     = (state_q == S_HALT);
  assign state      = state_q;

  logic unused_nop;
  assign unused_nop = (op == OP_NOP);

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: behavioural register file and imem,
// plus an instruction-level reference model of the CPU.
module tb_cpu_control_unit;
  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            run = 1'b0;
  logic [PC_W-1:0] imem_addr;
  logic [7:0]      imem_data;
  logic            rf_we;
  logic [1:0]      rf_waddr, rf_raddr1, rf_raddr2;
  logic [3:0]      rf_wdata, rf_rdata1, rf_rdata2;
  logic            zero_flag, carry_flag, halted;
  logic [2:0]      state;

  logic [7:0] imem [256];
  logic [3:0] rf [4];
  logic       tb_wr = 1'b0;
  logic [1:0] tb_wa = '0;
  logic [3:0] tb_wd = '0;

  int checks = 0;
  int failures = 0;

  // instruction-level model state
  int m_pc;
  int m_r [4];
  bit m_z, m_c, m_halt;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    else if (tb_wr) rf[tb_wa] <= tb_wd;
  end

  assign imem_data = imem[imem_addr];
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  cpu_control_unit #(.PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .zero_flag(zero_flag), .carry_flag(carry_flag),
    .halted(halted), .state(state)
  );

  task automatic fill_imem(input logic [7:0] v);
    for (int i = 0; i < 256; i++) imem[i] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_pc = 0; m_z = 0; m_c = 0; m_halt = 0;
  endtask

  task automatic preload_regs();
    for (int i = 0; i < 4; i++) begin
      tb_wr = 1'b1;
      tb_wa = 2'(i);
      tb_wd = 4'($urandom_range(0, 15));
      m_r[i] = int'(tb_wd);
      @(negedge clk);
    end
    tb_wr = 1'b0;
  endtask

  task automatic start_prog();
    do_reset();
    preload_regs();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    checks++;
    if (state !== 3'd1) begin
      failures++;
      $display("FAIL start: state=%0d required=1", state);
    end
  endtask

  // Executes one instruction on both the model and the DUT, starting at a FETCH cycle
  task automatic exec_one();
    int op, rd, rs, opnd, a, b, s, lat, exp_we, n, wes;
    op = int'(imem[m_pc]) / 16;
    rd = (int'(imem[m_pc]) / 4) % 4;
    rs = int'(imem[m_pc]) % 4;
    m_pc = (m_pc + 1) % 256;
    lat = 3; exp_we = 0; opnd = 0;
    if (op == 1 || op == 9 || op == 10) begin
      opnd = int'(imem[m_pc]);
      m_pc = (m_pc + 1) % 256;
      lat = 4;
    end
    a = m_r[rd]; b = m_r[rs];
    case (op)
      1:  begin m_r[rd] = opnd % 16; exp_we = 1; end
      2:  begin m_r[rd] = b; exp_we = 1; end
      3:  begin s = a + b; m_c = (s > 15); m_r[rd] = s % 16; m_z = (s % 16 == 0); exp_we = 1; end
      4:  begin m_c = (a < b); m_r[rd] = (a - b + 16) % 16; m_z = (a == b); exp_we = 1; end
      5:  begin s = a & b; m_r[rd] = s; m_z = (s == 0); m_c = 0; exp_we = 1; end
      6:  begin s = a | b; m_r[rd] = s; m_z = (s == 0); m_c = 0; exp_we = 1; end
      7:  begin s = a ^ b; m_r[rd] = s; m_z = (s == 0); m_c = 0; exp_we = 1; end
      8:  begin s = 15 - b; m_r[rd] = s; m_z = (s == 0); m_c = 0; exp_we = 1; end
      9:  m_pc = opnd;
      10: if (m_z) m_pc = opnd;
      15: begin m_halt = 1; lat = 2; end
      default: ;
    endcase

    checks++;
    if (state !== 3'd1) begin
      failures++;
      $display("FAIL exec_sync: state=%0d required=1", state);
    end
    n = 0; wes = 0;
    do begin
      wes += int'(rf_we);
      n++;
      @(negedge clk);
    end while (state !== 3'd1 && state !== 3'd5 && n < 8);

    checks++;
    if (n != lat) begin
      failures++;
      $display("FAIL latency: op=%0h cycles=%0d required=%0d", op, n, lat);
    end
    checks++;
    if (wes != exp_we) begin
      failures++;
      $display("FAIL we_pulses: op=%0h pulses=%0d required=%0d", op, wes, exp_we);
    end
    checks++;
    if (imem_addr !== PC_W'(m_pc)) begin
      failures++;
      $display("FAIL pc: op=%0h pc=%0h required=%0h", op, imem_addr, m_pc);
    end
    checks++;
    if (zero_flag !== m_z || carry_flag !== m_c) begin
      failures++;
      $display("FAIL flags: op=%0h zc=%b%b required=%b%b", op, zero_flag, carry_flag, m_z, m_c);
    end
    checks++;
    if (halted !== m_halt) begin
      failures++;
      $display("FAIL halted: op=%0h halted=%b required=%b", op, halted, m_halt);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rf[i] !== 4'(m_r[i])) begin
        failures++;
        $display("FAIL reg: op=%0h r%0d=%0h required=%0h", op, i, rf[i], m_r[i]);
      end
    end
  endtask

  task automatic test_reset();
    fill_imem(8'h00);
    imem[0] = 8'h10; imem[1] = 8'h07; imem[2] = 8'h33;
    start_prog();
    exec_one();
    exec_one();
    do_reset();
    checks++;
    if (state !== 3'd0 || imem_addr !== '0 || zero_flag !== 1'b0 || carry_flag !== 1'b0 ||
        halted !== 1'b0 || rf_we !== 1'b0) begin
      failures++;
      $display("FAIL reset: state=%0d pc=%0h z=%b c=%b halted=%b we=%b required 0", state,
               imem_addr, zero_flag, carry_flag, halted, rf_we);
    end
  endtask

  task automatic test_idle_hold();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (state !== 3'd0 || imem_addr !== '0) begin
        failures++;
        $display("FAIL idle_hold: state=%0d pc=%0h required 0/0", state, imem_addr);
      end
    end
  endtask

  task automatic test_add();
    fill_imem(8'h00);
    imem[0] = 8'h14; imem[1] = 8'h05;
    imem[2] = 8'h18; imem[3] = 8'h03;
    imem[4] = 8'h36;
    start_prog();
    for (int i = 0; i < 3; i++) exec_one();
    checks++;
    if (rf[1] !== 4'h8 || zero_flag !== 1'b0 || carry_flag !== 1'b0) begin
      failures++;
      $display("FAIL add: r1=%0h z=%b c=%b required r1=8 z=0 c=0", rf[1], zero_flag, carry_flag);
    end
  endtask

  task automatic test_jumps();
    fill_imem(8'h00);
    imem[0]    = 8'h10; imem[1]    = 8'h09;
    imem[2]    = 8'h1C; imem[3]    = 8'h07;
    imem[4]    = 8'h33;
    imem[5]    = 8'hA0; imem[6]    = 8'h20;
    imem[8'h20] = 8'h14; imem[8'h21] = 8'h03;
    imem[8'h22] = 8'h18; imem[8'h23] = 8'h05;
    imem[8'h24] = 8'h46;
    imem[8'h25] = 8'hA0; imem[8'h26] = 8'h00;
    imem[8'h27] = 8'hF0;
    start_prog();
    for (int i = 0; i < 3; i++) exec_one();
    checks++;
    if (rf[0] !== 4'h0 || zero_flag !== 1'b1 || carry_flag !== 1'b1) begin
      failures++;
      $display("FAIL add_carry: r0=%0h z=%b c=%b required r0=0 z=1 c=1", rf[0], zero_flag, carry_flag);
    end
    exec_one();
    checks++;
    if (imem_addr !== 8'h20) begin
      failures++;
      $display("FAIL jz_taken: pc=%0h required=20", imem_addr);
    end
    for (int i = 0; i < 3; i++) exec_one();
    checks++;
    if (rf[1] !== 4'hE || zero_flag !== 1'b0 || carry_flag !== 1'b1) begin
      failures++;
      $display("FAIL sub: r1=%0h z=%b c=%b required r1=e z=0 c=1", rf[1], zero_flag, carry_flag);
    end
    exec_one();
    checks++;
    if (imem_addr !== 8'h27) begin
      failures++;
      $display("FAIL jz_not_taken: pc=%0h required=27", imem_addr);
    end
  endtask

  task automatic test_logic();
    logic [3:0] exp_vals [4];
    logic [7:0] ops [4];
    exp_vals[0] = 4'h2; exp_vals[1] = 4'hE; exp_vals[2] = 4'hC; exp_vals[3] = 4'h9;
    ops[0] = 8'h59; ops[1] = 8'h69; ops[2] = 8'h79; ops[3] = 8'h89;
    for (int k = 0; k < 4; k++) begin
      fill_imem(8'h00);
      imem[0] = 8'h10; imem[1] = 8'h0A;
      imem[2] = 8'h14; imem[3] = 8'h06;
      imem[4] = 8'h1C; imem[5] = 8'h0F;
      imem[6] = 8'h3F;
      imem[7] = 8'h28;
      imem[8] = ops[k];
      start_prog();
      for (int i = 0; i < 4; i++) exec_one();
      checks++;
      if (carry_flag !== 1'b1) begin
        failures++;
        $display("FAIL logic_setup_carry: c=%b required=1", carry_flag);
      end
      exec_one();
      exec_one();
      checks++;
      if (rf[2] !== exp_vals[k] || carry_flag !== 1'b0 || zero_flag !== 1'b0) begin
        failures++;
        $display("FAIL logic_op%0h: r2=%0h c=%b z=%b required r2=%0h c=0 z=0", ops[k] >> 4,
                 rf[2], carry_flag, zero_flag, exp_vals[k]);
      end
    end
  endtask

  task automatic test_wrap();
    fill_imem(8'h00);
    imem[0] = 8'h90; imem[1] = 8'hFE;
    imem[8'hFE] = 8'h90; imem[8'hFF] = 8'h00;
    start_prog();
    exec_one();
    exec_one();
    checks++;
    if (imem_addr !== 8'h00) begin
      failures++;
      $display("FAIL jmp_wrap: pc=%0h required=00", imem_addr);
    end
    exec_one();
    exec_one();
    fill_imem(8'h00);
    imem[0] = 8'h90; imem[1] = 8'hFF;
    imem[8'hFF] = 8'h18;
    imem[1] = 8'hFF;
    imem[2] = 8'hF0;
    start_prog();
    exec_one();
    exec_one();
    checks++;
    if (imem_addr !== 8'h01 || rf[2] !== 4'h0) begin
      failures++;
      $display("FAIL straddle: pc=%0h r2=%0h required pc=01 r2=0", imem_addr, rf[2]);
    end
  endtask

  task automatic test_halt();
    fill_imem(8'h00);
    imem[0] = 8'h10; imem[1] = 8'h01;
    imem[2] = 8'hF0;
    start_prog();
    exec_one();
    exec_one();
    for (int i = 0; i < 100; i++) begin
      run = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (halted !== 1'b1 || state !== 3'd5 || rf_we !== 1'b0 || imem_addr !== 8'h03) begin
        failures++;
        $display("FAIL halt_sticky: cycle=%0d halted=%b state=%0d we=%b pc=%0h", i, halted,
                 state, rf_we, imem_addr);
      end
    end
    run = 1'b0;
  endtask

  task automatic test_reset_in_exec();
    fill_imem(8'h00);
    imem[0] = 8'h14; imem[1] = 8'h05;
    imem[2] = 8'h18; imem[3] = 8'h03;
    imem[4] = 8'h36;
    start_prog();
    exec_one();
    exec_one();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (state !== 3'd4 || rf_we !== 1'b1) begin
      failures++;
      $display("FAIL exec_reach: state=%0d we=%b required 4/1", state, rf_we);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rf_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_drop_we: we=%b required=0", rf_we);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (rf[1] !== 4'h5 || state !== 3'd0 || imem_addr !== '0 || zero_flag !== 1'b0 ||
        carry_flag !== 1'b0 || halted !== 1'b0 || rf_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_exec: r1=%0h state=%0d pc=%0h z=%b c=%b h=%b we=%b required r1=5 rest 0",
               rf[1], state, imem_addr, zero_flag, carry_flag, halted, rf_we);
    end
    m_pc = 0; m_z = 0; m_c = 0; m_halt = 0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 256; i++) imem[i] = 8'($urandom_range(0, 255));
      start_prog();
      for (int k = 0; k < 120; k++) begin
        exec_one();
        if (m_halt) break;
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_add();
    test_jumps();
    test_logic();
    test_wrap();
    test_halt();
    test_reset_in_exec();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
